// File: rtl/pipe_pkg.sv
// Shared encodings and constants for the pipeline hazard controller:
// FSM states, MemtoReg load code, mult/div latencies, forward selects, wait limit.
package pipe_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    localparam logic [1:0] MEMTOREG_LOAD = 2'b01;

    localparam int         MD_CNT_W    = 4;
    localparam logic [3:0] MD_LAT_MULT = 4'd5;
    localparam logic [3:0] MD_LAT_DIV  = 4'd10;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    localparam int         WAIT_CNT_W = 8;
    localparam logic [7:0] WAIT_LIMIT = 8'd255;

    // True when a source that is actually read collides with a live, non-$zero write.
    function automatic logic reg_hit(input logic [4:0] src, input logic src_used,
                                     input logic [4:0] dst, input logic dst_we);
        return dst_we && src_used && (dst != 5'd0) && (src == dst);
    endfunction

endpackage

// File: rtl/md_timer.sv
// Mult/div latency counter: loads a cycle count and decrements every clock,
// including pipeline freeze cycles; busy while nonzero.
module md_timer
    import pipe_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic [MD_CNT_W-1:0] load_val,
    output logic                busy
);

    logic [MD_CNT_W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign busy = (cnt != '0);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: memory-wait freeze, load-use / mult-div stalls,
// branch flush and forwarding selects. Define PIPE_CTRL_FWD_EN to enable forwarding.
module pipe_ctrl
    import pipe_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] rs_D,
    input  logic [4:0] rt_D,
    input  logic       use_rs_D,
    input  logic       use_rt_D,
    input  logic [4:0] WriteReg_E,
    input  logic [4:0] WriteReg_M,
    input  logic [4:0] WriteReg_W,
    input  logic       RegWrite_E,
    input  logic       RegWrite_M,
    input  logic       RegWrite_W,
    input  logic [1:0] MemtoReg_E,
    input  logic       md_start_D,
    input  logic       md_is_div_D,
    input  logic       md_use_D,
    input  logic       branch_taken_D,
    input  logic       dmem_req_M,
    input  logic       dmem_ready,
    output logic       stall_F,
    output logic       stall_D,
    output logic       stall_E,
    output logic       stall_M,
    output logic       flush_D,
    output logic       flush_E,
    output logic       flush_W,
    output logic       md_busy,
    output logic       mem_timeout,
    output logic [1:0] fwd_rs_D,
    output logic [1:0] fwd_rt_D
);

    state_t                state, next_state;
    logic [WAIT_CNT_W-1:0] wait_cnt;
    logic                  md_busy_int;
    logic                  md_accept;
    logic                  mem_freeze;
    logic                  raw_stall;
    logic                  decode_stall;
    logic                  hit_e_rs, hit_e_rt, hit_m_rs, hit_m_rt;
    logic                  load_in_e;
    logic [1:0]            fwd_rs_sel, fwd_rt_sel;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state <= next_state;
            if (next_state == RUN) begin
                wait_cnt <= '0;
            end else if (state == MEM_WAIT && wait_cnt != WAIT_LIMIT) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        mem_freeze = 1'b0;
        case (state)
            RUN: begin
                if (dmem_req_M && !dmem_ready) begin
                    next_state = MEM_WAIT;
                    mem_freeze = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (dmem_ready) next_state = RUN;
                else            mem_freeze = 1'b1;
            end
            default: next_state = RUN;
        endcase
    end

    assign hit_e_rs  = reg_hit(rs_D, use_rs_D, WriteReg_E, RegWrite_E);
    assign hit_e_rt  = reg_hit(rt_D, use_rt_D, WriteReg_E, RegWrite_E);
    assign hit_m_rs  = reg_hit(rs_D, use_rs_D, WriteReg_M, RegWrite_M);
    assign hit_m_rt  = reg_hit(rt_D, use_rt_D, WriteReg_M, RegWrite_M);
    assign load_in_e = (MemtoReg_E == MEMTOREG_LOAD);

`ifdef PIPE_CTRL_FWD_EN
    // Only a load still in E cannot be bypassed; MEM wins over WB when both match.
    assign raw_stall = load_in_e && (hit_e_rs || hit_e_rt);

    always_comb begin
        fwd_rs_sel = FWD_RF;
        fwd_rt_sel = FWD_RF;
        if (reg_hit(rs_D, 1'b1, WriteReg_M, RegWrite_M))      fwd_rs_sel = FWD_MEM;
        else if (reg_hit(rs_D, 1'b1, WriteReg_W, RegWrite_W)) fwd_rs_sel = FWD_WB;
        if (reg_hit(rt_D, 1'b1, WriteReg_M, RegWrite_M))      fwd_rt_sel = FWD_MEM;
        else if (reg_hit(rt_D, 1'b1, WriteReg_W, RegWrite_W)) fwd_rt_sel = FWD_WB;
    end
`else
    // No bypass network: any pending E/M write to a read source must drain first.
    // WB writes land before the regfile read, so W-stage fields are not needed.
    logic unused_wb;
    assign unused_wb  = ^{RegWrite_W, WriteReg_W, load_in_e};
    assign raw_stall  = hit_e_rs || hit_e_rt || hit_m_rs || hit_m_rt;
    assign fwd_rs_sel = FWD_RF;
    assign fwd_rt_sel = FWD_RF;
`endif

    assign decode_stall = raw_stall || (md_use_D && md_busy_int);
    assign md_accept    = md_start_D && !reset && !mem_freeze && !decode_stall && !md_busy_int;

    md_timer u_md_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (md_accept),
        .load_val (md_is_div_D ? MD_LAT_DIV : MD_LAT_MULT),
        .busy     (md_busy_int)
    );

    always_comb begin
        stall_F     = 1'b0;
        stall_D     = 1'b0;
        stall_E     = 1'b0;
        stall_M     = 1'b0;
        flush_D     = 1'b0;
        flush_E     = 1'b0;
        flush_W     = 1'b0;
        md_busy     = 1'b0;
        mem_timeout = 1'b0;
        fwd_rs_D    = FWD_RF;
        fwd_rt_D    = FWD_RF;
        if (!reset) begin
            md_busy     = md_busy_int;
            mem_timeout = (wait_cnt == WAIT_LIMIT);
            if (mem_freeze) begin
                stall_F = 1'b1;
                stall_D = 1'b1;
                stall_E = 1'b1;
                stall_M = 1'b1;
                flush_W = 1'b1;
            end else begin
                fwd_rs_D = fwd_rs_sel;
                fwd_rt_D = fwd_rt_sel;
                if (decode_stall) begin
                    stall_F = 1'b1;
                    stall_D = 1'b1;
                    flush_E = 1'b1;
                end else if (branch_taken_D) begin
                    flush_D = 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scenario bench for pipe_ctrl: per-cycle expected output words go through a
// scoreboard queue and are compared at the falling edge.
module tb_pipe_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rs_D, rt_D, WriteReg_E, WriteReg_M, WriteReg_W;
    logic       use_rs_D, use_rt_D, RegWrite_E, RegWrite_M, RegWrite_W;
    logic [1:0] MemtoReg_E;
    logic       md_start_D, md_is_div_D, md_use_D, branch_taken_D;
    logic       dmem_req_M, dmem_ready;
    logic       stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_W;
    logic       md_busy, mem_timeout;
    logic [1:0] fwd_rs_D, fwd_rt_D;

    pipe_ctrl dut (
        .clk(clk), .reset(reset),
        .rs_D(rs_D), .rt_D(rt_D), .use_rs_D(use_rs_D), .use_rt_D(use_rt_D),
        .WriteReg_E(WriteReg_E), .WriteReg_M(WriteReg_M), .WriteReg_W(WriteReg_W),
        .RegWrite_E(RegWrite_E), .RegWrite_M(RegWrite_M), .RegWrite_W(RegWrite_W),
        .MemtoReg_E(MemtoReg_E),
        .md_start_D(md_start_D), .md_is_div_D(md_is_div_D), .md_use_D(md_use_D),
        .branch_taken_D(branch_taken_D),
        .dmem_req_M(dmem_req_M), .dmem_ready(dmem_ready),
        .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E), .stall_M(stall_M),
        .flush_D(flush_D), .flush_E(flush_E), .flush_W(flush_W),
        .md_busy(md_busy), .mem_timeout(mem_timeout),
        .fwd_rs_D(fwd_rs_D), .fwd_rt_D(fwd_rt_D)
    );

    always #5 clk = ~clk;

    // Output word: {sF,sD,sE,sM,fD,fE,fW,busy,timeout,fwd_rs[1:0],fwd_rt[1:0]}
    localparam logic [12:0] O_NONE   = 13'h0000;
    localparam logic [12:0] B_SF     = 13'h1000;
    localparam logic [12:0] B_SD     = 13'h0800;
    localparam logic [12:0] B_SE     = 13'h0400;
    localparam logic [12:0] B_SM     = 13'h0200;
    localparam logic [12:0] B_FD     = 13'h0100;
    localparam logic [12:0] B_FE     = 13'h0080;
    localparam logic [12:0] B_FW     = 13'h0040;
    localparam logic [12:0] B_BUSY   = 13'h0020;
    localparam logic [12:0] B_TMO    = 13'h0010;
    localparam logic [12:0] B_RS_WB  = 13'h0008;
    localparam logic [12:0] B_RS_MEM = 13'h0004;
    localparam logic [12:0] B_RT_MEM = 13'h0001;
    localparam logic [12:0] O_FREEZE = B_SF | B_SD | B_SE | B_SM | B_FW;
    localparam logic [12:0] O_STALL  = B_SF | B_SD | B_FE;

    logic [12:0] obs;
    assign obs = {stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_W,
                  md_busy, mem_timeout, fwd_rs_D, fwd_rt_D};

    typedef struct {
        string       tag;
        logic [12:0] exp;
    } sb_t;

    sb_t sb_q[$];
    int  n_vec = 0;
    int  n_err = 0;

    task automatic check(input string tag, input logic [12:0] got, input logic [12:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic clr_inputs();
        reset = 1'b0;
        rs_D = 5'd0; rt_D = 5'd0; use_rs_D = 1'b0; use_rt_D = 1'b0;
        WriteReg_E = 5'd0; WriteReg_M = 5'd0; WriteReg_W = 5'd0;
        RegWrite_E = 1'b0; RegWrite_M = 1'b0; RegWrite_W = 1'b0;
        MemtoReg_E = 2'b00;
        md_start_D = 1'b0; md_is_div_D = 1'b0; md_use_D = 1'b0; branch_taken_D = 1'b0;
        dmem_req_M = 1'b0; dmem_ready = 1'b0;
    endtask

    // Inputs are already driven; record the expectation, compare mid-cycle, advance.
    task automatic step(input string tag, input logic [12:0] exp, input bit chk);
        if (chk) sb_q.push_back('{tag, exp});
        @(negedge clk);
        if (chk) begin
            sb_t e;
            e = sb_q.pop_front();
            check(e.tag, obs, e.exp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic load_e(input logic [4:0] r);
        RegWrite_E = 1'b1; MemtoReg_E = 2'b01; WriteReg_E = r;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with hazards present on the inputs: all outputs must stay quiet.
        clr_inputs();
        reset = 1'b1; dmem_req_M = 1'b1; branch_taken_D = 1'b1; md_use_D = 1'b1;
        load_e(5'd9); rs_D = 5'd9; use_rs_D = 1'b1;
        step("reset_quiet", O_NONE, 1);
        step("reset_quiet2", O_NONE, 1);
        clr_inputs();
        step("idle", O_NONE, 1);

        branch_taken_D = 1'b1;
        step("branch_flush", B_FD, 1);

        // Load-use on rs: load in E, then M, then W.
        clr_inputs(); load_e(5'd9); rs_D = 5'd9; use_rs_D = 1'b1;
        step("lu_rs_E", O_STALL, 1);
        clr_inputs(); RegWrite_M = 1'b1; WriteReg_M = 5'd9; rs_D = 5'd9; use_rs_D = 1'b1;
`ifdef PIPE_CTRL_FWD_EN
        step("lu_rs_M", B_RS_MEM, 1);
`else
        step("lu_rs_M", O_STALL, 1);
`endif
        clr_inputs(); RegWrite_W = 1'b1; WriteReg_W = 5'd9; rs_D = 5'd9; use_rs_D = 1'b1;
`ifdef PIPE_CTRL_FWD_EN
        step("lu_rs_W", B_RS_WB, 1);
`else
        step("lu_rs_W", O_NONE, 1);
`endif
        clr_inputs(); RegWrite_M = 1'b1; WriteReg_M = 5'd9;
        RegWrite_W = 1'b1; WriteReg_W = 5'd9; rs_D = 5'd9; use_rs_D = 1'b1;
`ifdef PIPE_CTRL_FWD_EN
        step("mem_beats_wb", B_RS_MEM, 1);
`else
        step("mem_beats_wb", O_STALL, 1);
`endif

        // $zero never hazards; unused rt never hazards; used rt does.
        clr_inputs(); load_e(5'd0); rs_D = 5'd0; use_rs_D = 1'b1;
        step("reg0_no_hazard", O_NONE, 1);
        clr_inputs(); load_e(5'd12); rt_D = 5'd12; use_rt_D = 1'b0;
        step("rt_unused", O_NONE, 1);
        use_rt_D = 1'b1;
        step("lu_rt_E", O_STALL, 1);
        clr_inputs(); RegWrite_M = 1'b1; WriteReg_M = 5'd12; rt_D = 5'd12; use_rt_D = 1'b1;
`ifdef PIPE_CTRL_FWD_EN
        step("rt_M", B_RT_MEM, 1);
`else
        step("rt_M", O_STALL, 1);
`endif

        // ALU (non-load) result in E.
        clr_inputs(); RegWrite_E = 1'b1; MemtoReg_E = 2'b00; WriteReg_E = 5'd7;
        rs_D = 5'd7; use_rs_D = 1'b1;
`ifdef PIPE_CTRL_FWD_EN
        step("alu_E", O_NONE, 1);
`else
        step("alu_E", O_STALL, 1);
`endif

        // Branch together with load-use: stall wins, flush follows.
        clr_inputs(); branch_taken_D = 1'b1; load_e(5'd9); rs_D = 5'd9; use_rs_D = 1'b1;
        step("br_lu_1", O_STALL, 1);
        clr_inputs(); branch_taken_D = 1'b1; RegWrite_M = 1'b1; WriteReg_M = 5'd9;
        rs_D = 5'd9; use_rs_D = 1'b1;
`ifdef PIPE_CTRL_FWD_EN
        step("br_lu_2", B_FD | B_RS_MEM, 1);
`else
        step("br_lu_2", O_STALL, 1);
`endif
        clr_inputs(); branch_taken_D = 1'b1; RegWrite_W = 1'b1; WriteReg_W = 5'd9;
        rs_D = 5'd9; use_rs_D = 1'b1;
`ifdef PIPE_CTRL_FWD_EN
        step("br_lu_3", B_FD | B_RS_WB, 1);
`else
        step("br_lu_3", B_FD, 1);
`endif

        // Memory freeze, 3 cycles; other hazards present must be masked.
        clr_inputs(); dmem_req_M = 1'b1;
        step("freeze_0", O_FREEZE, 1);
        branch_taken_D = 1'b1; load_e(5'd9); rs_D = 5'd9; use_rs_D = 1'b1;
        step("freeze_1_prio", O_FREEZE, 1);
        clr_inputs(); dmem_req_M = 1'b1;
        step("freeze_2", O_FREEZE, 1);
        dmem_ready = 1'b1;
        step("freeze_ready", O_NONE, 1);
        clr_inputs();
        step("freeze_run", O_NONE, 1);

        // Long wait: timeout asserts after 255 wait cycles and clears once ready.
        clr_inputs(); dmem_req_M = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (i == 0 || i == 100 || i == 250)
                step("tmo_low", O_FREEZE, 1);
            else if (i == 260 || i == 299)
                step("tmo_high", O_FREEZE | B_TMO, 1);
            else
                step("tmo_wait", O_FREEZE, 0);
        end
        dmem_ready = 1'b1;
        step("tmo_ready", O_NONE, 0);
        clr_inputs();
        step("tmo_cleared", O_NONE, 1);

        // div then mfhi: 10 busy/stall cycles, proceeds on cycle 11.
        clr_inputs(); md_start_D = 1'b1; md_is_div_D = 1'b1; md_use_D = 1'b1;
        step("div_accept", O_NONE, 1);
        clr_inputs(); md_use_D = 1'b1;
        for (int i = 1; i <= 10; i++) step("div_mfhi_stall", O_STALL | B_BUSY, 1);
        step("div_mfhi_go", O_NONE, 1);

        // mult (5 cycles); a second start while busy is refused.
        clr_inputs(); md_start_D = 1'b1;
        step("mult_accept", O_NONE, 1);
        clr_inputs();
        step("mult_busy1", B_BUSY, 1);
        step("mult_busy2", B_BUSY, 1);
        md_start_D = 1'b1; md_is_div_D = 1'b1; md_use_D = 1'b1;
        step("mult_restart_refused", O_STALL | B_BUSY, 1);
        clr_inputs();
        step("mult_busy4", B_BUSY, 1);
        step("mult_busy5", B_BUSY, 1);
        step("mult_done", O_NONE, 1);

        // div counter keeps running through a memory freeze.
        clr_inputs(); md_start_D = 1'b1; md_is_div_D = 1'b1;
        step("divf_accept", O_NONE, 1);
        clr_inputs(); dmem_req_M = 1'b1;
        for (int i = 1; i <= 3; i++) step("divf_freeze", O_FREEZE | B_BUSY, 1);
        dmem_ready = 1'b1;
        step("divf_ready", B_BUSY, 1);
        clr_inputs();
        for (int i = 5; i <= 10; i++) step("divf_busy", B_BUSY, 1);
        step("divf_done", O_NONE, 1);

        // Reset in the middle of a memory wait with a divide in flight.
        clr_inputs(); md_start_D = 1'b1; md_is_div_D = 1'b1;
        step("rst_mid_div", O_NONE, 1);
        clr_inputs(); dmem_req_M = 1'b1;
        step("rst_mid_f0", O_FREEZE | B_BUSY, 1);
        step("rst_mid_f1", O_FREEZE | B_BUSY, 1);
        reset = 1'b1; md_use_D = 1'b1; branch_taken_D = 1'b1;
        step("rst_mid_reset", O_NONE, 1);
        clr_inputs(); md_use_D = 1'b1;
        step("rst_mid_after", O_NONE, 1);

        if (sb_q.size() != 0) check("scoreboard_drained", 13'(sb_q.size()), 13'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
